// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed binary-to-7-segment display:
// active-low segment patterns, FSM state type and the nibble decoder.
package seg7_pkg;

    // Segment order is {G,F,E,D,C,B,A}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    function automatic logic [6:0] nibble_to_seg(logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic longint unsigned pow10(int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_7seg_mux_if.sv
// Valid/ready input channel carrying the binary value to be displayed.
interface bin_to_7seg_mux_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] bin_in;
    logic             bin_valid;
    logic             bin_ready;

    modport master (output bin_in, output bin_valid, input bin_ready);
    modport slave  (input bin_in, input bin_valid, output bin_ready);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: accepts one value per handshake,
// produces NDIGITS BCD digits after WIDTH shift cycles plus one DONE cycle.
module bin_to_bcd_seq
    import seg7_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NDIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    bin_to_7seg_mux_if.slave     bus,
    output logic [4*NDIGITS-1:0] bcd_out,
    output logic                 conv_done,
    output logic                 load,
    output logic [4*NDIGITS-1:0] result,
    output logic                 result_ovf
);
    localparam int BW = 4 * NDIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam longint unsigned MAX_VAL = pow10(NDIGITS) - 64'd1;

    state_t            state_reg;
    logic [WIDTH-1:0]  bin_reg;
    logic [BW-1:0]     bcd_reg;
    logic [CW-1:0]     cnt_reg;
    logic              ovf_reg;

    logic [BW-1:0]       bcd_adj;
    logic [BW+WIDTH-1:0] shift_next;

    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // Bits leaving the top of the BCD field are dropped; overflow flags that case.
    assign shift_next    = {bcd_adj, bin_reg} << 1;
    assign bus.bin_ready = (state_reg == IDLE);
    assign load          = (state_reg == DONE);
    assign result        = bcd_reg;
    assign result_ovf    = ovf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            bin_reg   <= '0;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            bcd_out   <= '0;
            conv_done <= 1'b0;
        end else begin
            conv_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.bin_valid) begin
                        bin_reg   <= bus.bin_in;
                        bcd_reg   <= '0;
                        cnt_reg   <= '0;
                        ovf_reg   <= (64'(bus.bin_in) > MAX_VAL);
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_reg, bin_reg} <= shift_next;
                    cnt_reg            <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    bcd_out   <= bcd_reg;
                    conv_done <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/bin_to_7seg_mux.sv
// Binary value to time-multiplexed NDIGITS 7-segment display with
// leading-zero blanking and overflow dashes.
module bin_to_7seg_mux
    import seg7_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NDIGITS  = 3,
    parameter int SCAN_DIV = 50000,
    parameter int LZB      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    bin_to_7seg_mux_if.slave     bus,
    output logic [4*NDIGITS-1:0] bcd_out,
    output logic                 conv_done,
    output logic [6:0]           seg_out,
    output logic [NDIGITS-1:0]   an_out
);
    localparam int BW = 4 * NDIGITS;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    logic          load;
    logic [BW-1:0] result;
    logic          result_ovf;

    bin_to_bcd_seq #(
        .WIDTH   (WIDTH),
        .NDIGITS (NDIGITS)
    ) u_conv (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .bcd_out    (bcd_out),
        .conv_done  (conv_done),
        .load       (load),
        .result     (result),
        .result_ovf (result_ovf)
    );

    logic [BW-1:0] disp_bcd_reg;
    logic          disp_ovf_reg;
    logic          disp_valid_reg;
    logic [PW-1:0] pre_reg;
    logic [IW-1:0] idx_reg;

    logic [NDIGITS-1:0] nz_above;
    logic [6:0]         digit_seg [NDIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_digit
            // Nonzero anywhere from this digit upward keeps it lit.
            assign nz_above[gi] = |disp_bcd_reg[BW-1:gi*4];
            assign digit_seg[gi] =
                !disp_valid_reg                             ? SEG_BLANK :
                disp_ovf_reg                                ? SEG_DASH  :
                ((LZB != 0) && (gi > 0) && !nz_above[gi])   ? SEG_BLANK :
                nibble_to_seg(disp_bcd_reg[gi*4 +: 4]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_reg        <= '0;
            idx_reg        <= '0;
            disp_bcd_reg   <= '0;
            disp_ovf_reg   <= 1'b0;
            disp_valid_reg <= 1'b0;
            seg_out        <= SEG_BLANK;
            an_out         <= '1;
        end else begin
            if (pre_reg == PW'(SCAN_DIV - 1)) begin
                pre_reg <= '0;
                idx_reg <= (idx_reg == IW'(NDIGITS - 1)) ? '0 : idx_reg + 1'b1;
            end else begin
                pre_reg <= pre_reg + 1'b1;
            end

            if (load) begin
                disp_bcd_reg   <= result;
                disp_ovf_reg   <= result_ovf;
                disp_valid_reg <= 1'b1;
            end

            seg_out <= digit_seg[idx_reg];
            an_out  <= ~(NDIGITS'(1) << idx_reg);
        end
    end

endmodule

// File: tb/tb_bin_to_7seg_mux.sv
// Randomized bench for two display configurations (3 digits, 2 digits) against
// a cycle-scheduled reference built from decimal arithmetic.
module tb_bin_to_7seg_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b0;
    logic rst1 = 1'b0;

    bin_to_7seg_mux_if #(.WIDTH(8)) bus0 ();
    bin_to_7seg_mux_if #(.WIDTH(8)) bus1 ();

    logic [11:0] bcd0;
    logic        done0;
    logic [6:0]  seg0;
    logic [2:0]  an0;
    logic [7:0]  bcd1;
    logic        done1;
    logic [6:0]  seg1;
    logic [1:0]  an1;

    bin_to_7seg_mux #(.WIDTH(8), .NDIGITS(3), .SCAN_DIV(4), .LZB(1)) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0),
        .bcd_out(bcd0), .conv_done(done0), .seg_out(seg0), .an_out(an0)
    );

    bin_to_7seg_mux #(.WIDTH(8), .NDIGITS(2), .SCAN_DIV(4), .LZB(1)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1),
        .bcd_out(bcd1), .conv_done(done1), .seg_out(seg1), .an_out(an1)
    );

    localparam int SCAN = 4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en [2]   = '{1'b0, 1'b0};
    int nd [2]       = '{3, 2};

    int rst_edge [2];
    int xfer_edge [2];
    int xfer_val [2];
    bit pend [2];
    int stage_at [2];
    int stage_val [2];
    bit shown_valid [2];
    int shown_val [2];
    int bcd_exp [2];

    logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

    function automatic int p10(int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int ref_bcd(int v, int n);
        int r = 0;
        for (int k = 0; k < n; k++) r = r | (((v / p10(k)) % 10) << (4 * k));
        return r;
    endfunction

    function automatic logic [6:0] ref_seg(bit valid, int v, int k, int n);
        if (!valid)          return 7'b1111111;
        if (v >= p10(n))     return 7'b0111111;
        if (k > 0 && v < p10(k)) return 7'b1111111;
        return segtab[(v / p10(k)) % 10];
    endfunction

    function automatic bit model_ready(int d);
        return !(pend[d] && cyc >= xfer_edge[d] && cyc < xfer_edge[d] + 9);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor(int d, logic [11:0] bcd, logic done, logic [6:0] seg,
                           logic [2:0] an, logic rdy);
        int c    = cyc;
        int n    = nd[d];
        int all1 = (1 << n) - 1;
        int k;
        string p = (d == 0) ? "d0" : "d1";
        if (c == rst_edge[d]) begin
            shown_valid[d] = 1'b0;
            bcd_exp[d]     = 0;
            pend[d]        = 1'b0;
            stage_at[d]    = -1;
            check({p, " rst_an"},   32'(an),   32'(all1));
            check({p, " rst_seg"},  32'(seg),  32'h7f);
            check({p, " rst_done"}, 32'(done), 32'd0);
            check({p, " rst_bcd"},  32'(bcd),  32'd0);
            check({p, " rst_rdy"},  32'(rdy),  32'd1);
            return;
        end
        if (pend[d] && c == xfer_edge[d] + 9) begin
            bcd_exp[d]   = ref_bcd(xfer_val[d], n);
            stage_at[d]  = c + 1;
            stage_val[d] = xfer_val[d];
        end
        if (c == stage_at[d]) begin
            shown_valid[d] = 1'b1;
            shown_val[d]   = stage_val[d];
        end
        k = ((c - rst_edge[d] - 1) / SCAN) % n;
        check({p, " an"},   32'(an),  32'(all1 & ~(1 << k)));
        check({p, " seg"},  32'(seg), 32'(ref_seg(shown_valid[d], shown_val[d], k, n)));
        check({p, " done"}, 32'(done), 32'(pend[d] && c == xfer_edge[d] + 9));
        check({p, " bcd"},  32'(bcd),  32'(bcd_exp[d]));
        check({p, " rdy"},  32'(rdy),
              32'(!(pend[d] && c >= xfer_edge[d] && c < xfer_edge[d] + 9)));
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (mon_en[0]) monitor(0, bcd0, done0, seg0, an0, bus0.bin_ready);
        if (mon_en[1]) monitor(1, {4'b0, bcd1}, done1, seg1, {1'b0, an1}, bus1.bin_ready);
    end

    task automatic do_reset(int d, int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (d == 0) rst0 = 1'b1; else rst1 = 1'b1;
            rst_edge[d] = cyc + 1;
            mon_en[d]   = 1'b1;
        end
        @(negedge clk);
        if (d == 0) rst0 = 1'b0; else rst1 = 1'b0;
    endtask

    task automatic send(int d, int v);
        @(negedge clk);
        if (d == 0) begin
            bus0.bin_in = 8'(v); bus0.bin_valid = 1'b1;
        end else begin
            bus1.bin_in = 8'(v); bus1.bin_valid = 1'b1;
        end
        if (model_ready(d)) begin
            xfer_edge[d] = cyc + 1;
            xfer_val[d]  = v;
            pend[d]      = 1'b1;
        end
        @(negedge clk);
        bus0.bin_valid = 1'b0;
        bus1.bin_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus0.bin_in = '0; bus0.bin_valid = 1'b0;
        bus1.bin_in = '0; bus1.bin_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0; stage_at[d] = -1; shown_valid[d] = 1'b0;
            shown_val[d] = 0; bcd_exp[d] = 0; xfer_edge[d] = 0; rst_edge[d] = 0;
        end
        do_reset(0, 3);
        do_reset(1, 2);
        idle(14);

        send(0, 255); idle(24);
        send(0, 7);   idle(20);
        send(0, 0);   idle(16);
        send(1, 100); idle(18);
        send(1, 42);  idle(18);

        send(0, 123); idle(2);
        send(0, 99);  idle(20);

        send(0, 200); idle(3);
        do_reset(0, 1);
        idle(14);
        send(0, 86);  idle(16);

        for (int i = 0; i < 60; i++) begin
            int d = int'($urandom_range(0, 1));
            int v = int'($urandom_range(0, 255));
            send(d, v);
            idle(int'($urandom_range(0, 14)));
            if ($urandom_range(0, 11) == 0) do_reset(d, 1);
        end
        idle(24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
